// File: rtl/zorro2_pkg.sv
// Shared definitions for the Zorro II autoconfig chain: controller states,
// the config page address and the autoconfig register offsets ({A[6:1],0}).
package zorro2_pkg;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_PRESENT,
        ST_WAIT_AS,
        ST_DONE
    } cfg_state_t;

    localparam logic [7:0] CFG_PAGE = 8'hE8;

    localparam logic [6:0] OFS_TYPE_HI  = 7'h00;
    localparam logic [6:0] OFS_TYPE_LO  = 7'h02;
    localparam logic [6:0] OFS_PROD_HI  = 7'h04;
    localparam logic [6:0] OFS_PROD_LO  = 7'h06;
    localparam logic [6:0] OFS_FLAGS_HI = 7'h08;
    localparam logic [6:0] OFS_FLAGS_LO = 7'h0A;
    localparam logic [6:0] OFS_MANUF_0  = 7'h10;
    localparam logic [6:0] OFS_MANUF_1  = 7'h12;
    localparam logic [6:0] OFS_MANUF_2  = 7'h14;
    localparam logic [6:0] OFS_MANUF_3  = 7'h16;
    localparam logic [6:0] OFS_ROMVEC_0 = 7'h28;
    localparam logic [6:0] OFS_ROMVEC_1 = 7'h2A;
    localparam logic [6:0] OFS_ROMVEC_2 = 7'h2C;
    localparam logic [6:0] OFS_ROMVEC_3 = 7'h2E;
    localparam logic [6:0] OFS_BASE_HI  = 7'h48;
    localparam logic [6:0] OFS_BASE_LO  = 7'h4A;
    localparam logic [6:0] OFS_SHUTUP   = 7'h4C;

endpackage

// File: rtl/zorro2_nybble_rom.sv
// Autoconfig read-back nybble for the board currently presented. Only the
// er_Type nybbles are returned true; everything else is stored inverted on
// the bus, and unmapped offsets read as all ones.
module zorro2_nybble_rom
    import zorro2_pkg::*;
(
    input  logic [7:0]  er_type,
    input  logic [7:0]  er_prod,
    input  logic [7:0]  er_flags,
    input  logic [15:0] manuf,
    input  logic [15:0] romvec,
    input  logic [6:0]  offset,
    output logic [3:0]  nybble
);

    // offset-to-nybble lookup
    always_comb begin
        nybble = 4'hF;
        case (offset)
            OFS_TYPE_HI:  nybble = er_type[7:4];
            OFS_TYPE_LO:  nybble = er_type[3:0];
            OFS_PROD_HI:  nybble = ~er_prod[7:4];
            OFS_PROD_LO:  nybble = ~er_prod[3:0];
            OFS_FLAGS_HI: nybble = ~er_flags[7:4];
            OFS_FLAGS_LO: nybble = ~er_flags[3:0];
            OFS_MANUF_0:  nybble = ~manuf[15:12];
            OFS_MANUF_1:  nybble = ~manuf[11:8];
            OFS_MANUF_2:  nybble = ~manuf[7:4];
            OFS_MANUF_3:  nybble = ~manuf[3:0];
            OFS_ROMVEC_0: nybble = ~romvec[15:12];
            OFS_ROMVEC_1: nybble = ~romvec[11:8];
            OFS_ROMVEC_2: nybble = ~romvec[7:4];
            OFS_ROMVEC_3: nybble = ~romvec[3:0];
            default:      nybble = 4'hF;
        endcase
    end

endmodule

// File: rtl/zorro2_autoconfig_chain.sv
// Presents N_BOARDS Zorro II autoconfig boards one after another on the
// config page, then releases CFGOUT_n to the next slot.
//
// state      | meaning
// SCAN       | step idx past jumpered-off boards, one per clock
// PRESENT    | board idx answers config-page reads/writes
// WAIT_AS    | board just configured/shut up; hold until AS_n releases
// DONE       | chain finished, CFGOUT_n low, no longer answering
module zorro2_autoconfig_chain
    import zorro2_pkg::*;
#(
    parameter int                       N_BOARDS    = 2,
    parameter logic [15:0]              MANUF_ID    = 16'h082C,
    parameter logic [N_BOARDS*8-1:0]    BOARD_TYPE  = {8'hC1, 8'hE0},
    parameter logic [N_BOARDS*8-1:0]    BOARD_PROD  = {8'h02, 8'h01},
    parameter logic [N_BOARDS*8-1:0]    BOARD_FLAGS = {8'h00, 8'h00},
    parameter logic [N_BOARDS*16-1:0]   BOARD_ROMVEC = {16'h4000, 16'h0000}
)
(
    input  logic                    C7M,
    input  logic                    RESET,
    input  logic                    CFGIN_n,
    input  logic                    AS_n,
    input  logic                    DS_n,
    input  logic                    RW_n,
    input  logic [7:0]              A_HIGH,
    input  logic [5:0]              A_LOW,
    input  logic [3:0]              D_IN,
    input  logic [N_BOARDS-1:0]     BOARD_EN,
    output logic [3:0]              D_OUT,
    output logic                    D_OE,
    output logic [N_BOARDS*8-1:0]   BASE,
    output logic [N_BOARDS-1:0]     CONFIGURED,
    output logic [N_BOARDS-1:0]     SHUTUP,
    output logic                    CFGOUT_n
);

    localparam logic [2:0] IDX_END = 3'(N_BOARDS);

    logic [1:0] cfgin_sr, as_sr, ds_sr, rw_sr;
    logic       cfgin_s, as_s, ds_s, rw_s;

    cfg_state_t state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] low_q;
    logic       wr_done_q;
    logic [N_BOARDS*8-1:0] base_q;
    logic [N_BOARDS-1:0]   cfg_q, shut_q;
    logic [3:0] d_out_q;
    logic       d_oe_q, cfgout_n_q;

    logic [6:0]  offset;
    logic        hit, read_hit, write_hit;
    logic        load_low, load_base, set_shut;
    logic        en_sel;
    logic [7:0]  sel_type, sel_prod, sel_flags;
    logic [15:0] sel_romvec;
    logic [3:0]  rom_nybble;

    assign cfgin_s = cfgin_sr[1];
    assign as_s    = as_sr[1];
    assign ds_s    = ds_sr[1];
    assign rw_s    = rw_sr[1];
    assign offset  = {A_LOW, 1'b0};

    // two-flop synchronisers for the asynchronous bus strobes
    always_ff @(posedge C7M) begin
        if (RESET) begin
            cfgin_sr <= 2'b11;
            as_sr    <= 2'b11;
            ds_sr    <= 2'b11;
            rw_sr    <= 2'b11;
        end else begin
            cfgin_sr <= {cfgin_sr[0], CFGIN_n};
            as_sr    <= {as_sr[0], AS_n};
            ds_sr    <= {ds_sr[0], DS_n};
            rw_sr    <= {rw_sr[0], RW_n};
        end
    end

    // select jumper and ID parameters of the board idx points at
    always_comb begin
        en_sel     = 1'b0;
        sel_type   = 8'h00;
        sel_prod   = 8'h00;
        sel_flags  = 8'h00;
        sel_romvec = 16'h0000;
        for (int i = 0; i < N_BOARDS; i++) begin
            if (idx_q == 3'(i)) begin
                en_sel     = BOARD_EN[i];
                sel_type   = BOARD_TYPE[i*8 +: 8];
                sel_prod   = BOARD_PROD[i*8 +: 8];
                sel_flags  = BOARD_FLAGS[i*8 +: 8];
                sel_romvec = BOARD_ROMVEC[i*16 +: 16];
            end
        end
    end

    zorro2_nybble_rom u_rom (
        .er_type  (sel_type),
        .er_prod  (sel_prod),
        .er_flags (sel_flags),
        .manuf    (MANUF_ID),
        .romvec   (sel_romvec),
        .offset   (offset),
        .nybble   (rom_nybble)
    );

    // wr_done_q limits a write to one action per AS cycle even if DS_n stays low
    assign hit       = !as_s && !cfgin_s && (A_HIGH == CFG_PAGE) && (state_q == ST_PRESENT);
    assign read_hit  = hit && rw_s;
    assign write_hit = hit && !rw_s && !ds_s && !wr_done_q;

    // next-state and register-write decode
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        load_low  = 1'b0;
        load_base = 1'b0;
        set_shut  = 1'b0;
        case (state_q)
            ST_SCAN: begin
                if (idx_q >= IDX_END)
                    state_d = ST_DONE;
                else if (en_sel)
                    state_d = ST_PRESENT;
                else
                    idx_d = idx_q + 3'd1;
            end
            ST_PRESENT: begin
                if (write_hit) begin
                    case (offset)
                        OFS_BASE_LO: load_low = 1'b1;
                        OFS_BASE_HI: begin
                            load_base = 1'b1;
                            idx_d     = idx_q + 3'd1;
                            state_d   = ST_WAIT_AS;
                        end
                        OFS_SHUTUP: begin
                            set_shut = 1'b1;
                            idx_d    = idx_q + 3'd1;
                            state_d  = ST_WAIT_AS;
                        end
                        default: ;
                    endcase
                end
            end
            ST_WAIT_AS: begin
                if (as_s)
                    state_d = ST_SCAN;
            end
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_SCAN;
        endcase
    end

    // FSM state and board index
    always_ff @(posedge C7M) begin
        if (RESET) begin
            state_q <= ST_SCAN;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // holding nybble, per-board base/status, and the write-once flag
    always_ff @(posedge C7M) begin
        if (RESET) begin
            low_q     <= 4'h0;
            wr_done_q <= 1'b0;
            base_q    <= '0;
            cfg_q     <= '0;
            shut_q    <= '0;
        end else begin
            if (load_low)
                low_q <= D_IN;
            if (write_hit)
                wr_done_q <= 1'b1;
            else if (as_s)
                wr_done_q <= 1'b0;
            for (int i = 0; i < N_BOARDS; i++) begin
                if (idx_q == 3'(i)) begin
                    if (load_base) begin
                        base_q[i*8 +: 8] <= {D_IN, low_q};
                        cfg_q[i]         <= 1'b1;
                    end
                    if (set_shut)
                        shut_q[i] <= 1'b1;
                end
            end
        end
    end

    // registered bus read data and chain output; CFGOUT_n also needs our own CFGIN_n low
    always_ff @(posedge C7M) begin
        if (RESET) begin
            d_out_q    <= 4'h0;
            d_oe_q     <= 1'b0;
            cfgout_n_q <= 1'b1;
        end else begin
            if (read_hit) begin
                d_oe_q  <= 1'b1;
                d_out_q <= rom_nybble;
            end else if (as_s || state_q == ST_DONE) begin
                d_oe_q  <= 1'b0;
                d_out_q <= 4'h0;
            end
            cfgout_n_q <= !((state_d == ST_DONE) && !cfgin_s);
        end
    end

    assign D_OUT      = d_out_q;
    assign D_OE       = d_oe_q;
    assign BASE       = base_q;
    assign CONFIGURED = cfg_q;
    assign SHUTUP     = shut_q;
    assign CFGOUT_n   = cfgout_n_q;

endmodule

// File: tb/tb_zorro2_autoconfig_chain.sv
// Bench for the autoconfig chain: directed scenarios plus randomized bus
// traffic checked against a board-list model of the autoconfig protocol.
module tb_zorro2_autoconfig_chain;

    localparam int          N        = 2;
    localparam logic [15:0] P_MANUF  = 16'h082C;
    localparam logic [15:0] P_TYPE   = {8'hC1, 8'hE0};
    localparam logic [15:0] P_PROD   = {8'h02, 8'h01};
    localparam logic [15:0] P_FLAGS  = {8'h00, 8'h00};
    localparam logic [31:0] P_ROMVEC = {16'h4000, 16'h0000};

    logic           C7M = 1'b0;
    logic           RESET, CFGIN_n, AS_n, DS_n, RW_n;
    logic [7:0]     A_HIGH;
    logic [5:0]     A_LOW;
    logic [3:0]     D_IN;
    logic [N-1:0]   BOARD_EN;
    logic [3:0]     D_OUT;
    logic           D_OE;
    logic [N*8-1:0] BASE;
    logic [N-1:0]   CONFIGURED, SHUTUP;
    logic           CFGOUT_n;

    int checks = 0;
    int errors = 0;

    // model: which board is being presented, and what each board has been told
    int             m_cur;
    logic [3:0]     m_low;
    logic [N*8-1:0] m_base;
    logic [N-1:0]   m_cfg, m_shut;

    zorro2_autoconfig_chain #(
        .N_BOARDS     (N),
        .MANUF_ID     (P_MANUF),
        .BOARD_TYPE   (P_TYPE),
        .BOARD_PROD   (P_PROD),
        .BOARD_FLAGS  (P_FLAGS),
        .BOARD_ROMVEC (P_ROMVEC)
    ) dut (
        .C7M        (C7M),
        .RESET      (RESET),
        .CFGIN_n    (CFGIN_n),
        .AS_n       (AS_n),
        .DS_n       (DS_n),
        .RW_n       (RW_n),
        .A_HIGH     (A_HIGH),
        .A_LOW      (A_LOW),
        .D_IN       (D_IN),
        .BOARD_EN   (BOARD_EN),
        .D_OUT      (D_OUT),
        .D_OE       (D_OE),
        .BASE       (BASE),
        .CONFIGURED (CONFIGURED),
        .SHUTUP     (SHUTUP),
        .CFGOUT_n   (CFGOUT_n)
    );

    always #5 C7M = ~C7M;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end

    // first enabled board at or after p (N means none left)
    function automatic int scan_from(int p);
        int q = p;
        while (q < N && !BOARD_EN[q]) q++;
        return q;
    endfunction

    // autoconfig register bytes sit at 4-byte strides, high nybble first;
    // only the type byte is presented true
    function automatic logic [3:0] exp_nyb(int b, logic [6:0] ofs);
        logic [15:0] ty = P_TYPE;
        logic [15:0] pr = P_PROD;
        logic [15:0] fl = P_FLAGS;
        logic [15:0] mf = P_MANUF;
        logic [31:0] rv = P_ROMVEC;
        logic [7:0]  rb;
        logic        inv;
        logic [3:0]  n;
        inv = 1'b1;
        rb  = 8'h00;
        case (ofs & 7'h7C)
            7'h00: begin rb = ty[b*8 +: 8]; inv = 1'b0; end
            7'h04: rb = pr[b*8 +: 8];
            7'h08: rb = fl[b*8 +: 8];
            7'h10: rb = mf[15:8];
            7'h14: rb = mf[7:0];
            7'h28: rb = rv[b*16+8 +: 8];
            7'h2C: rb = rv[b*16 +: 8];
            default: return 4'hF;
        endcase
        n = ofs[1] ? rb[3:0] : rb[7:4];
        return inv ? ~n : n;
    endfunction

    task automatic model_reset();
        m_low  = 4'h0;
        m_base = '0;
        m_cfg  = '0;
        m_shut = '0;
        m_cur  = scan_from(0);
    endtask

    task automatic model_write(input logic [7:0] ah, input logic [6:0] ofs, input logic [3:0] d);
        if (ah != 8'hE8 || CFGIN_n || m_cur >= N) return;
        case (ofs)
            7'h4A: m_low = d;
            7'h48: begin
                m_base[m_cur*8 +: 8] = {d, m_low};
                m_cfg[m_cur] = 1'b1;
                m_cur = scan_from(m_cur + 1);
            end
            7'h4C: begin
                m_shut[m_cur] = 1'b1;
                m_cur = scan_from(m_cur + 1);
            end
            default: ;
        endcase
    endtask

    task automatic do_reset();
        @(negedge C7M);
        RESET = 1'b1;
        AS_n = 1'b1; DS_n = 1'b1; RW_n = 1'b1;
        repeat (2) @(negedge C7M);
        RESET = 1'b0;
        model_reset();
    endtask

    task automatic bus_read(input logic [7:0] ah, input logic [6:0] ofs,
                            output logic [3:0] data, output logic oe, output logic oe_after);
        @(negedge C7M);
        A_HIGH = ah; A_LOW = ofs[6:1]; RW_n = 1'b1; AS_n = 1'b0; DS_n = 1'b0;
        repeat (5) @(negedge C7M);
        data = D_OUT;
        oe   = D_OE;
        AS_n = 1'b1; DS_n = 1'b1;
        repeat (4) @(negedge C7M);
        oe_after = D_OE;
    endtask

    task automatic bus_write(input logic [7:0] ah, input logic [6:0] ofs, input logic [3:0] d, input int hold);
        @(negedge C7M);
        A_HIGH = ah; A_LOW = ofs[6:1]; RW_n = 1'b0; D_IN = d; AS_n = 1'b0;
        @(negedge C7M);
        DS_n = 1'b0;
        repeat (hold) @(negedge C7M);
        AS_n = 1'b1; DS_n = 1'b1;
        repeat (8) @(negedge C7M);
        RW_n = 1'b1;
    endtask

    task automatic test_reset();
        BOARD_EN = 2'b11;
        CFGIN_n  = 1'b0;
        do_reset();
        @(negedge C7M);
        checks++; if (BASE !== 16'h0000) begin errors++; $display("FAIL reset_base: got %h want 0000", BASE); end
        checks++; if (CONFIGURED !== 2'b00) begin errors++; $display("FAIL reset_configured: got %b want 00", CONFIGURED); end
        checks++; if (SHUTUP !== 2'b00) begin errors++; $display("FAIL reset_shutup: got %b want 00", SHUTUP); end
        checks++; if (D_OE !== 1'b0) begin errors++; $display("FAIL reset_d_oe: got %b want 0", D_OE); end
        checks++; if (D_OUT !== 4'h0) begin errors++; $display("FAIL reset_d_out: got %h want 0", D_OUT); end
        checks++; if (CFGOUT_n !== 1'b1) begin errors++; $display("FAIL reset_cfgout: got %b want 1", CFGOUT_n); end
    endtask

    task automatic test_read_map();
        logic [3:0] d;
        logic oe, oe_after;
        logic [6:0] ofs;
        bus_read(8'hE8, 7'h00, d, oe, oe_after);
        checks++; if (oe !== 1'b1 || d !== 4'hE) begin errors++; $display("FAIL read_00: got oe=%b d=%h want oe=1 d=E", oe, d); end
        checks++; if (oe_after !== 1'b0) begin errors++; $display("FAIL read_oe_release: got %b want 0", oe_after); end
        bus_read(8'hE8, 7'h02, d, oe, oe_after);
        checks++; if (oe !== 1'b1 || d !== 4'h0) begin errors++; $display("FAIL read_02: got oe=%b d=%h want oe=1 d=0", oe, d); end
        bus_read(8'hE8, 7'h04, d, oe, oe_after);
        checks++; if (oe !== 1'b1 || d !== 4'hF) begin errors++; $display("FAIL read_04: got oe=%b d=%h want oe=1 d=F", oe, d); end
        for (int k = 0; k < 12; k++) begin
            ofs = 7'($urandom_range(0, 63)) << 1;
            bus_read(8'hE8, ofs, d, oe, oe_after);
            checks++;
            if (oe !== 1'b1 || d !== exp_nyb(m_cur, ofs) || oe_after !== 1'b0) begin
                errors++;
                $display("FAIL read_rand ofs=%h: got oe=%b d=%h after=%b want oe=1 d=%h after=0",
                         ofs, oe, d, oe_after, exp_nyb(m_cur, ofs));
            end
        end
    endtask

    task automatic test_configure();
        logic [3:0] d;
        logic oe, oe_after;
        bus_write(8'hE8, 7'h4A, 4'h0, 2); model_write(8'hE8, 7'h4A, 4'h0);
        bus_write(8'hE8, 7'h48, 4'h2, 2); model_write(8'hE8, 7'h48, 4'h2);
        checks++; if (BASE[7:0] !== 8'h20) begin errors++; $display("FAIL cfg_base0: got %h want 20", BASE[7:0]); end
        checks++; if (CONFIGURED !== 2'b01) begin errors++; $display("FAIL cfg_configured: got %b want 01", CONFIGURED); end
        bus_read(8'hE8, 7'h00, d, oe, oe_after);
        checks++; if (oe !== 1'b1 || d !== 4'hC) begin errors++; $display("FAIL cfg_next_read: got oe=%b d=%h want oe=1 d=C", oe, d); end
    endtask

    // CFGOUT_n goes low four samples after raw AS_n rises: two synchroniser
    // clocks, then WAIT_AS->SCAN and SCAN->DONE
    task automatic test_shutup();
        int cnt;
        logic [3:0] d;
        logic oe, oe_after;
        @(negedge C7M);
        A_HIGH = 8'hE8; A_LOW = 6'(7'h4C >> 1); RW_n = 1'b0; D_IN = 4'h0; AS_n = 1'b0;
        @(negedge C7M);
        DS_n = 1'b0;
        repeat (2) @(negedge C7M);
        checks++; if (CFGOUT_n !== 1'b1) begin errors++; $display("FAIL shut_cfgout_early: got %b want 1", CFGOUT_n); end
        AS_n = 1'b1; DS_n = 1'b1;
        cnt = 0;
        while (CFGOUT_n !== 1'b0 && cnt < 12) begin
            @(negedge C7M);
            cnt++;
        end
        RW_n = 1'b1;
        model_write(8'hE8, 7'h4C, 4'h0);
        checks++; if (CFGOUT_n !== 1'b0 || cnt != 4) begin errors++; $display("FAIL shut_cfgout_timing: got cfgout=%b after %0d clocks want 0 after 4", CFGOUT_n, cnt); end
        checks++; if (SHUTUP !== 2'b10) begin errors++; $display("FAIL shut_shutup: got %b want 10", SHUTUP); end
        checks++; if (BASE[15:8] !== 8'h00) begin errors++; $display("FAIL shut_base1: got %h want 00", BASE[15:8]); end
        bus_read(8'hE8, 7'h00, d, oe, oe_after);
        checks++; if (oe !== 1'b0) begin errors++; $display("FAIL done_no_oe: got %b want 0", oe); end
    endtask

    task automatic test_all_disabled();
        int cnt;
        BOARD_EN = 2'b00;
        do_reset();
        cnt = 0;
        while (CFGOUT_n !== 1'b0 && cnt < 10) begin
            @(negedge C7M);
            cnt++;
        end
        checks++; if (CFGOUT_n !== 1'b0 || cnt > N + 1) begin errors++; $display("FAIL all_disabled_done: got cfgout=%b after %0d clocks want 0 within %0d", CFGOUT_n, cnt, N + 1); end
    endtask

    task automatic test_skip_board();
        logic [3:0] d;
        logic oe, oe_after;
        BOARD_EN = 2'b10;
        do_reset();
        bus_read(8'hE8, 7'h00, d, oe, oe_after);
        checks++; if (oe !== 1'b1 || d !== 4'hC) begin errors++; $display("FAIL skip_read: got oe=%b d=%h want oe=1 d=C", oe, d); end
        bus_write(8'hE8, 7'h48, 4'hE, 2); model_write(8'hE8, 7'h48, 4'hE);
        checks++; if (CFGOUT_n !== 1'b0) begin errors++; $display("FAIL skip_cfgout: got %b want 0", CFGOUT_n); end
        checks++; if (CONFIGURED !== 2'b10) begin errors++; $display("FAIL skip_configured: got %b want 10", CONFIGURED); end
        checks++; if (BASE !== 16'hE000) begin errors++; $display("FAIL skip_base: got %h want E000", BASE); end
    endtask

    task automatic test_cfgin_high_and_reset();
        logic [3:0] d;
        logic oe, oe_after;
        BOARD_EN = 2'b11;
        do_reset();
        CFGIN_n = 1'b1;
        bus_read(8'hE8, 7'h00, d, oe, oe_after);
        checks++; if (oe !== 1'b0) begin errors++; $display("FAIL cfgin_high_oe: got %b want 0", oe); end
        bus_write(8'hE8, 7'h48, 4'h3, 2); model_write(8'hE8, 7'h48, 4'h3);
        checks++; if (CONFIGURED !== 2'b00 || CFGOUT_n !== 1'b1) begin errors++; $display("FAIL cfgin_high_write: got cfg=%b cfgout=%b want 00 1", CONFIGURED, CFGOUT_n); end
        CFGIN_n = 1'b0;
        bus_write(8'hE8, 7'h4A, 4'h5, 2); model_write(8'hE8, 7'h4A, 4'h5);
        bus_write(8'hE8, 7'h48, 4'h7, 2); model_write(8'hE8, 7'h48, 4'h7);
        checks++; if (BASE !== 16'h0075 || CONFIGURED !== 2'b01) begin errors++; $display("FAIL pre_reset_cfg: got base=%h cfg=%b want 0075 01", BASE, CONFIGURED); end
        // reset lands in the middle of an active read of board 1
        @(negedge C7M);
        A_HIGH = 8'hE8; A_LOW = 6'h00; RW_n = 1'b1; AS_n = 1'b0; DS_n = 1'b0;
        repeat (5) @(negedge C7M);
        checks++; if (D_OE !== 1'b1) begin errors++; $display("FAIL mid_read_oe: got %b want 1", D_OE); end
        RESET = 1'b1;
        @(negedge C7M);
        checks++;
        if (BASE !== 16'h0000 || CONFIGURED !== 2'b00 || CFGOUT_n !== 1'b1 || D_OE !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got base=%h cfg=%b cfgout=%b oe=%b want 0000 00 1 0", BASE, CONFIGURED, CFGOUT_n, D_OE);
        end
        AS_n = 1'b1; DS_n = 1'b1;
        @(negedge C7M);
        RESET = 1'b0;
        model_reset();
        repeat (4) @(negedge C7M);
    endtask

    task automatic test_ds_hold();
        logic [3:0] d;
        logic oe, oe_after;
        BOARD_EN = 2'b11;
        do_reset();
        bus_write(8'hE8, 7'h48, 4'h3, 4); model_write(8'hE8, 7'h48, 4'h3);
        checks++; if (CONFIGURED !== 2'b01 || BASE !== 16'h0030) begin errors++; $display("FAIL ds_hold_cfg: got cfg=%b base=%h want 01 0030", CONFIGURED, BASE); end
        bus_read(8'hE8, 7'h00, d, oe, oe_after);
        checks++; if (oe !== 1'b1 || d !== 4'hC) begin errors++; $display("FAIL ds_hold_idx: got oe=%b d=%h want oe=1 d=C", oe, d); end
    endtask

    task automatic test_random_chain();
        logic [3:0] d, wd;
        logic oe, oe_after, exp_oe;
        logic [6:0] ofs;
        logic [7:0] ah;
        int op;
        CFGIN_n = 1'b0;
        for (int it = 0; it < 10; it++) begin
            BOARD_EN = N'($urandom_range(0, 3));
            do_reset();
            repeat (4) @(negedge C7M);
            for (int k = 0; k < 8; k++) begin
                op = $urandom_range(0, 5);
                ah = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255)) : 8'hE8;
                wd = 4'($urandom_range(0, 15));
                if (op <= 1) begin
                    ofs = 7'($urandom_range(0, 63)) << 1;
                    bus_read(ah, ofs, d, oe, oe_after);
                    exp_oe = (ah == 8'hE8) && (m_cur < N);
                    checks++;
                    if (oe !== exp_oe || oe_after !== 1'b0 || (exp_oe && d !== exp_nyb(m_cur, ofs))) begin
                        errors++;
                        $display("FAIL rand_read ah=%h ofs=%h: got oe=%b d=%h after=%b want oe=%b d=%h after=0",
                                 ah, ofs, oe, d, oe_after, exp_oe, exp_nyb(m_cur, ofs));
                    end
                end else begin
                    case (op)
                        2: ofs = 7'h4A;
                        3: ofs = 7'h48;
                        4: ofs = 7'h4C;
                        default: begin
                            ofs = 7'($urandom_range(0, 63)) << 1;
                            if (ofs == 7'h48 || ofs == 7'h4A || ofs == 7'h4C) ofs = 7'h50;
                        end
                    endcase
                    bus_write(ah, ofs, wd, $urandom_range(2, 4));
                    model_write(ah, ofs, wd);
                    checks++;
                    if (BASE !== m_base || CONFIGURED !== m_cfg || SHUTUP !== m_shut || CFGOUT_n !== (m_cur < N)) begin
                        errors++;
                        $display("FAIL rand_write ah=%h ofs=%h d=%h: got base=%h cfg=%b shut=%b cfgout=%b want %h %b %b %b",
                                 ah, ofs, wd, BASE, CONFIGURED, SHUTUP, CFGOUT_n, m_base, m_cfg, m_shut, (m_cur < N));
                    end
                    // boards not yet reached may be re-jumpered
                    if (m_cur < N - 1 && $urandom_range(0, 2) == 0) begin
                        for (int b = m_cur + 1; b < N; b++) BOARD_EN[b] = 1'($urandom_range(0, 1));
                    end
                end
            end
        end
    endtask

    initial begin
        RESET = 1'b1; CFGIN_n = 1'b0; AS_n = 1'b1; DS_n = 1'b1; RW_n = 1'b1;
        A_HIGH = 8'h00; A_LOW = 6'h00; D_IN = 4'h0; BOARD_EN = 2'b11;
        test_reset();
        test_read_map();
        test_configure();
        test_shutup();
        test_all_disabled();
        test_skip_board();
        test_cfgin_high_and_reset();
        test_ds_hold();
        test_random_chain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
